door_lock_seq: RTL and testbench

DOOR_LOCK_SEQ -- requirements
Module: door_lock_seq

---
 rtl/door_lock_seq.sv | 135 +++++++++++++
 tb/tb_door_lock_seq.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/door_lock_seq.sv
// door_lock_seq: keypad door lock with failed-attempt lockout and in-field code reprogramming.
// Outputs are registered from the next state, so each outcome shows in the cycle after its accepting edge.
module door_lock_seq #(
  parameter int KEY_W       = 8,
  parameter int CODE_LEN    = 4,
  parameter int MAX_TRIES   = 3,
  parameter int UNLOCK_CYC  = 8,
  parameter int LOCKOUT_CYC = 16,
  parameter logic [KEY_W*CODE_LEN-1:0] DEFAULT_CODE = {8'h12, 8'h34, 8'h56, 8'h78}
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [KEY_W-1:0]               key,
  input  logic                           key_valid,
  input  logic                           prog,
  output logic                           locked,
  output logic                           unlocked,
  output logic                           error,
  output logic                           lockout,
  output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt
);
  localparam int IW = CODE_LEN > 1 ? $clog2(CODE_LEN) : 1;
  localparam int FW = $clog2(MAX_TRIES + 1);
  localparam int TM = UNLOCK_CYC > LOCKOUT_CYC ? UNLOCK_CYC : LOCKOUT_CYC;
  localparam int TW = TM > 1 ? $clog2(TM) : 1;
  localparam logic [2:0] S_LOCKED   = 3'd0;
  localparam logic [2:0] S_ENTRY    = 3'd1;
  localparam logic [2:0] S_UNLOCKED = 3'd2;
  localparam logic [2:0] S_PROGRAM  = 3'd3;
  localparam logic [2:0] S_LOCKOUT  = 3'd4;

  logic [2:0]       r_state, w_state;
  logic [IW-1:0]    r_idx, w_idx;
  logic             r_mis, w_mis;
  logic [TW-1:0]    r_timer, w_timer;
  logic [FW-1:0]    r_fail, w_fail, w_fail_inc;
  logic [KEY_W-1:0] r_code [CODE_LEN];
  logic [KEY_W-1:0] r_shadow [CODE_LEN];
  logic             r_locked, r_unlocked, r_error, r_lockout;
  logic             w_err, w_last, w_bad, w_sh_we, w_commit, w_open;

  assign w_last     = r_idx == IW'(CODE_LEN - 1);
  assign w_bad      = r_mis | (key != r_code[r_idx]);
  assign w_fail_inc = r_fail == FW'(MAX_TRIES) ? r_fail : r_fail + 1'b1;
  assign w_open     = w_state == S_UNLOCKED || w_state == S_PROGRAM;

  always_comb begin
    w_state  = r_state;
    w_idx    = r_idx;
    w_mis    = r_mis;
    w_timer  = r_timer;
    w_fail   = r_fail;
    w_err    = 1'b0;
    w_sh_we  = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      S_LOCKED, S_ENTRY: if (key_valid) begin
        if (w_last) begin
          w_idx = '0;
          w_mis = 1'b0;
          if (w_bad) begin
            w_err   = 1'b1;
            w_fail  = w_fail_inc;
            w_state = w_fail_inc == FW'(MAX_TRIES) ? S_LOCKOUT : S_LOCKED;
            w_timer = TW'(LOCKOUT_CYC - 1);
          end else begin
            w_fail  = '0;
            w_state = S_UNLOCKED;
            w_timer = TW'(UNLOCK_CYC - 1);
          end
        end else begin
          w_idx   = r_idx + 1'b1;
          w_mis   = w_bad;
          w_state = S_ENTRY;
        end
      end
      S_UNLOCKED: begin
        if (key_valid && prog) w_state = S_PROGRAM;
        else if (r_timer == '0) w_state = S_LOCKED;
        else w_timer = r_timer - 1'b1;
      end
      // The final digit bypasses the shadow and lands with the rest in one commit.
      S_PROGRAM: if (key_valid) begin
        w_sh_we  = 1'b1;
        w_commit = w_last;
        w_idx    = w_last ? '0 : r_idx + 1'b1;
        w_state  = w_last ? S_LOCKED : S_PROGRAM;
      end
      S_LOCKOUT: begin
        if (r_timer == '0) begin
          w_state = S_LOCKED;
          w_fail  = '0;
        end else w_timer = r_timer - 1'b1;
      end
      default: w_state = S_LOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_LOCKED;
      r_idx      <= '0;
      r_mis      <= 1'b0;
      r_timer    <= '0;
      r_fail     <= '0;
      r_locked   <= 1'b1;
      r_unlocked <= 1'b0;
      r_error    <= 1'b0;
      r_lockout  <= 1'b0;
      for (int i = 0; i < CODE_LEN; i++) begin
        r_code[i]   <= DEFAULT_CODE[KEY_W*(CODE_LEN-1-i) +: KEY_W];
        r_shadow[i] <= '0;
      end
    end else begin
      r_state    <= w_state;
      r_idx      <= w_idx;
      r_mis      <= w_mis;
      r_timer    <= w_timer;
      r_fail     <= w_fail;
      r_locked   <= !w_open;
      r_unlocked <= w_open;
      r_error    <= w_err;
      r_lockout  <= w_state == S_LOCKOUT;
      if (w_sh_we) r_shadow[r_idx] <= key;
      if (w_commit)
        for (int i = 0; i < CODE_LEN; i++) r_code[i] <= i == CODE_LEN - 1 ? key : r_shadow[i];
    end
  end

  assign locked   = r_locked;
  assign unlocked = r_unlocked;
  assign error    = r_error;
  assign lockout  = r_lockout;
  assign fail_cnt = r_fail;
endmodule

// File: tb/tb_door_lock_seq.sv
// tb_door_lock_seq: directed and random keypad traffic scored cycle by cycle against a queue-based model.
module tb_door_lock_seq;
  localparam int CL = 4, MT = 3, UC = 8, LC = 16;
  typedef struct packed {logic l, u, e, lo; logic [1:0] f;} exp_t;

  logic       clk = 1'b0, rst = 1'b0, key_valid = 1'b0, prog = 1'b0;
  logic [7:0] key = 8'h00;
  logic       locked, unlocked, error, lockout;
  logic [1:0] fail_cnt;
  exp_t       sb[$];
  int         errors = 0, checks = 0;

  logic [7:0] m_code [CL];
  logic [7:0] m_sh[$], m_ent[$];
  int         m_unl, m_lck, m_fails;
  bit         m_prg, m_err;

  always #5 clk = ~clk;

  door_lock_seq dut (
    .clk(clk), .rst(rst), .key(key), .key_valid(key_valid), .prog(prog),
    .locked(locked), .unlocked(unlocked), .error(error), .lockout(lockout), .fail_cnt(fail_cnt)
  );

  task automatic m_reset();
    m_code = '{8'h12, 8'h34, 8'h56, 8'h78};
    m_sh.delete();
    m_ent.delete();
    m_unl = 0; m_lck = 0; m_fails = 0; m_prg = 0; m_err = 0;
  endtask

  task automatic m_update(input bit kv, input logic [7:0] k, input bit p);
    bit ok;
    m_err = 0;
    if (m_lck > 0) begin
      m_lck--;
      if (m_lck == 0) m_fails = 0;
    end else if (m_prg) begin
      if (kv) begin
        m_sh.push_back(k);
        if (m_sh.size() == CL) begin
          for (int i = 0; i < CL; i++) m_code[i] = m_sh[i];
          m_sh.delete();
          m_prg = 0;
        end
      end
    end else if (m_unl > 0) begin
      if (kv && p) begin
        m_prg = 1;
        m_unl = 0;
      end else m_unl--;
    end else if (kv) begin
      m_ent.push_back(k);
      if (m_ent.size() == CL) begin
        ok = 1;
        for (int i = 0; i < CL; i++) if (m_ent[i] != m_code[i]) ok = 0;
        m_ent.delete();
        if (ok) begin
          m_unl = UC;
          m_fails = 0;
        end else begin
          m_err = 1;
          if (m_fails < MT) m_fails++;
          if (m_fails == MT) m_lck = LC;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit kv, input logic [7:0] k, input bit p);
    exp_t e;
    @(negedge clk);
    rst = r; key_valid = kv; key = k; prog = p;
    if (!r) m_reset();
    else m_update(kv, k, p);
    e.u  = m_unl > 0 || m_prg;
    e.l  = !e.u;
    e.e  = m_err;
    e.lo = m_lck > 0;
    e.f  = 2'(m_fails);
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 8'h00, 0);
  endtask

  task automatic code4(input logic [31:0] c, input int gap);
    for (int i = 3; i >= 0; i--) begin
      step(1, 1, c[8*i +: 8], 0);
      idle(gap);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if ({locked, unlocked, error, lockout, fail_cnt} !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got l=%b u=%b e=%b lo=%b f=%0d want l=%b u=%b e=%b lo=%b f=%0d",
                   $time, locked, unlocked, error, lockout, fail_cnt, e.l, e.u, e.e, e.lo, e.f);
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] k;
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    code4(32'h12345678, 0); idle(10);
    code4(32'h12340078, 0); idle(2);
    code4(32'h12345678, 0); idle(10);
    for (int t = 0; t < 3; t++) begin
      code4(32'h11223344, 0); idle(1);
    end
    code4(32'h12345678, 0); idle(14);
    step(1, 0, 8'h00, 0);
    step(1, 1, 8'h55, 1);
    code4(32'hAABBCCDD, 0); idle(2);
    code4(32'h12345678, 0); idle(2);
    code4(32'hAABBCCDD, 0); idle(10);
    code4(32'hAABBCCDD, 0);
    step(1, 1, 8'h00, 1);
    step(1, 1, 8'hAA, 1);
    step(1, 1, 8'hBB, 0);
    step(0, 0, 8'h00, 0);
    step(1, 1, 8'h12, 0);
    step(1, 1, 8'h34, 0);
    step(1, 1, 8'h56, 0);
    step(1, 1, 8'h78, 0);
    idle(10);
    code4(32'h12345678, 5); idle(10);
    code4(32'h99345678, 0); idle(3);
    for (int n = 0; n < 3000; n++) begin
      if (!m_prg && m_ent.size() < CL && $urandom_range(0, 3) != 0) k = m_code[m_ent.size()];
      else k = 8'($urandom);
      step($urandom_range(0, 299) != 0, $urandom_range(0, 2) != 0, k, $urandom_range(0, 5) == 0);
    end
    idle(2);
    for (int w = 0; w < 10 && sb.size() != 0; w++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
